sm83_bus_arbiter: RTL and testbench

- Sits between sm83_core's memory bus and the system memory.
- Owns the OAM DMA register at 0xFF46 and sequences the 160-byte OAM DMA copy.
- Arbitrates memory ports between CPU and DMA. While DMA owns the bus, the CPU reaches only HRAM (0xFF80–0xFFFE), which always sits on a dedicated HRAM port.

---
 rtl/sm83_pkg.sv | 30 +++
 rtl/sm83_bus_arbiter_oam_dma_seq.sv | 120 ++++++++++++
 rtl/sm83_bus_arbiter.sv | 92 +++++++++
 tb/tb_sm83_bus_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sm83_pkg.sv
// Shared types and constants for the SM83 memory-bus blocks.
// Holds the bus word types, the OAM DMA state encoding and the fixed
// addresses the bus arbiter decodes.
package sm83_pkg;

    typedef logic [15:0] addr_t;
    typedef logic [7:0]  data_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        START  = 2'd1,
        ACTIVE = 2'd2
    } dma_state_t;

    localparam addr_t DMA_REG_ADDR = 16'hFF46;
    localparam addr_t OAM_BASE     = 16'hFE00;
    localparam addr_t HRAM_LO      = 16'hFF80;
    localparam addr_t HRAM_HI      = 16'hFFFE;

    // True when an address falls in high RAM, which is never locked out.
    function automatic logic is_hram(input addr_t a);
        return (a >= HRAM_LO) && (a <= HRAM_HI);
    endfunction

    // Sources at or above 0xE0 alias the work-RAM echo, so bit 5 is dropped.
    function automatic data_t clamp_src(input data_t s);
        return (s >= 8'hE0) ? (s & 8'hDF) : s;
    endfunction

endpackage

// File: rtl/sm83_bus_arbiter_oam_dma_seq.sv
// OAM DMA sequencer: FF46 source latch, IDLE/START/ACTIVE FSM, byte slot and
// byte index counters, and the one-cycle completion pulse.
// Optional build macro SM83_DMA_RESTART_EN: when defined, an FF46 write while
// a transfer is pending or running restarts it from the new source; when
// undefined, such a write only updates the readback value.
module oam_dma_seq
    import sm83_pkg::*;
#(
    parameter int CYCLES_PER_BYTE = 1,
    parameter int OAM_LEN         = 160
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       reg_wen,
    input  data_t      reg_wdata,
    output data_t      dma_src,
    output data_t      src_eff,
    output logic [7:0] idx,
    output logic       dma_active,
    output logic       xfer_wen,
    output logic       dma_done
);

    localparam logic [2:0] SLOT_LAST = 3'(CYCLES_PER_BYTE - 1);
    localparam logic [7:0] IDX_LAST  = 8'(OAM_LEN - 1);

    dma_state_t state_q, state_d;
    logic [7:0] idx_q, idx_d;
    logic [2:0] slot_q, slot_d;
    data_t      dma_src_q, dma_src_d;
    data_t      src_cap_q, src_cap_d;
    logic       dma_done_q, dma_done_d;

    // State register: every sequencer flop, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= 8'h00;
            slot_q     <= 3'd0;
            dma_src_q  <= 8'h00;
            src_cap_q  <= 8'h00;
            dma_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            slot_q     <= slot_d;
            dma_src_q  <= dma_src_d;
            src_cap_q  <= src_cap_d;
            dma_done_q <= dma_done_d;
        end
    end

    // Next-state logic: FSM transitions, counter stepping and source capture.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        slot_d     = slot_q;
        dma_src_d  = dma_src_q;
        src_cap_d  = src_cap_q;
        dma_done_d = 1'b0;

        // FF46 readback always tracks the last value written.
        if (reg_wen) begin
            dma_src_d = reg_wdata;
        end

        case (state_q)
            IDLE: begin
                if (reg_wen) begin
                    state_d   = START;
                    src_cap_d = clamp_src(reg_wdata);
                end
            end
            START: begin
                state_d = ACTIVE;
                idx_d   = 8'h00;
                slot_d  = 3'd0;
            end
            ACTIVE: begin
                if (slot_q == SLOT_LAST) begin
                    slot_d = 3'd0;
                    if (idx_q == IDX_LAST) begin
                        state_d    = IDLE;
                        idx_d      = 8'h00;
                        dma_done_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 8'd1;
                    end
                end else begin
                    slot_d = slot_q + 3'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef SM83_DMA_RESTART_EN
        // A new FF46 write abandons the current transfer without a done pulse.
        if (reg_wen && (state_q != IDLE)) begin
            state_d    = START;
            src_cap_d  = clamp_src(reg_wdata);
            idx_d      = 8'h00;
            slot_d     = 3'd0;
            dma_done_d = 1'b0;
        end
`endif
    end

    // Outputs: bus ownership, per-byte write strobe and registered status.
    always_comb begin
        dma_active = (state_q == ACTIVE);
        xfer_wen   = (state_q == ACTIVE) && (slot_q == 3'd0);
        dma_src    = dma_src_q;
        src_eff    = src_cap_q;
        idx        = idx_q;
        dma_done   = dma_done_q;
    end

endmodule

// File: rtl/sm83_bus_arbiter.sv
// SM83 bus arbiter: sits between the core bus and system memory, owns the
// FF46 OAM DMA register and hands the memory ports to the DMA sequencer
// while a copy runs. HRAM always has its own port and stays CPU-reachable.
// Optional build macro SM83_DMA_RESTART_EN (see oam_dma_seq).
module sm83_bus_arbiter
    import sm83_pkg::*;
#(
    parameter int CYCLES_PER_BYTE = 1,
    parameter int OAM_LEN         = 160
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_r_addr,
    input  logic [15:0] cpu_w_addr,
    input  logic [7:0]  cpu_w_data,
    input  logic        cpu_w_wen,
    output logic [7:0]  cpu_r_data,
    output logic [15:0] mem_r_addr,
    input  logic [7:0]  mem_r_data,
    output logic [15:0] mem_w_addr,
    output logic [7:0]  mem_w_data,
    output logic        mem_w_wen,
    output logic [6:0]  hram_r_addr,
    input  logic [7:0]  hram_r_data,
    output logic [6:0]  hram_w_addr,
    output logic [7:0]  hram_w_data,
    output logic        hram_w_wen,
    output logic        dma_active,
    output logic        dma_done
);

    logic       r_is_hram, r_is_reg, w_is_hram, w_is_reg, reg_wen;
    data_t      dma_src, src_eff;
    logic [7:0] idx;
    logic       xfer_wen;

    // Address decode for the CPU read and write ports.
    always_comb begin
        r_is_hram = is_hram(cpu_r_addr);
        r_is_reg  = (cpu_r_addr == DMA_REG_ADDR);
        w_is_hram = is_hram(cpu_w_addr);
        w_is_reg  = (cpu_w_addr == DMA_REG_ADDR);
        reg_wen   = cpu_w_wen && w_is_reg;
    end

    oam_dma_seq #(
        .CYCLES_PER_BYTE (CYCLES_PER_BYTE),
        .OAM_LEN         (OAM_LEN)
    ) u_seq (
        .clk        (clk),
        .rst        (rst),
        .reg_wen    (reg_wen),
        .reg_wdata  (cpu_w_data),
        .dma_src    (dma_src),
        .src_eff    (src_eff),
        .idx        (idx),
        .dma_active (dma_active),
        .xfer_wen   (xfer_wen),
        .dma_done   (dma_done)
    );

    // Port muxing: DMA owns mem while active; HRAM and FF46 bypass mem always.
    always_comb begin
        hram_r_addr = cpu_r_addr[6:0];
        hram_w_addr = cpu_w_addr[6:0];
        hram_w_data = cpu_w_data;
        hram_w_wen  = cpu_w_wen && w_is_hram;

        if (r_is_hram) begin
            cpu_r_data = hram_r_data;
        end else if (r_is_reg) begin
            cpu_r_data = dma_src;
        end else if (dma_active) begin
            cpu_r_data = 8'hFF;
        end else begin
            cpu_r_data = mem_r_data;
        end

        if (dma_active) begin
            mem_r_addr = {src_eff, idx};
            mem_w_addr = OAM_BASE + {8'h00, idx};
            mem_w_data = mem_r_data;
            mem_w_wen  = xfer_wen;
        end else begin
            mem_r_addr = cpu_r_addr;
            mem_w_addr = cpu_w_addr;
            mem_w_data = cpu_w_data;
            mem_w_wen  = cpu_w_wen && !w_is_hram && !w_is_reg;
        end
    end

endmodule

// File: tb/tb_sm83_bus_arbiter.sv
// Directed bench for sm83_bus_arbiter: one instance with one clock per DMA
// byte and one with four, each backed by its own memory and HRAM model.
module tb_sm83_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] cpu_r_addr = 16'h0000;
    logic [15:0] cpu_w_addr = 16'h0000;
    logic [7:0]  cpu_w_data = 8'h00;
    logic        cpu_w_wen  = 1'b0;

    logic [7:0]  cpu_r_data1, m1_r_data, m1_w_data, h1_r_data, h1_w_data;
    logic [15:0] m1_r_addr, m1_w_addr;
    logic [6:0]  h1_r_addr, h1_w_addr;
    logic        m1_w_wen, h1_w_wen, act1, done1;

    logic [7:0]  cpu_r_data4, m4_r_data, m4_w_data, h4_r_data, h4_w_data;
    logic [15:0] m4_r_addr, m4_w_addr;
    logic [6:0]  h4_r_addr, h4_w_addr;
    logic        m4_w_wen, h4_w_wen, act4, done4;

    logic [7:0]  mem1 [0:65535];
    logic [7:0]  mem4 [0:65535];
    logic [7:0]  hram1 [0:127];
    logic [7:0]  hram4 [0:127];

    logic        pl_en = 1'b0;
    int          pl_sel = 0;
    logic [15:0] pl_addr = 16'h0000;
    logic [7:0]  pl_data = 8'h00;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    sm83_bus_arbiter #(.CYCLES_PER_BYTE(1), .OAM_LEN(160)) dut1 (
        .clk(clk), .rst(rst),
        .cpu_r_addr(cpu_r_addr), .cpu_w_addr(cpu_w_addr),
        .cpu_w_data(cpu_w_data), .cpu_w_wen(cpu_w_wen),
        .cpu_r_data(cpu_r_data1),
        .mem_r_addr(m1_r_addr), .mem_r_data(m1_r_data),
        .mem_w_addr(m1_w_addr), .mem_w_data(m1_w_data), .mem_w_wen(m1_w_wen),
        .hram_r_addr(h1_r_addr), .hram_r_data(h1_r_data),
        .hram_w_addr(h1_w_addr), .hram_w_data(h1_w_data), .hram_w_wen(h1_w_wen),
        .dma_active(act1), .dma_done(done1)
    );

    sm83_bus_arbiter #(.CYCLES_PER_BYTE(4), .OAM_LEN(160)) dut4 (
        .clk(clk), .rst(rst),
        .cpu_r_addr(cpu_r_addr), .cpu_w_addr(cpu_w_addr),
        .cpu_w_data(cpu_w_data), .cpu_w_wen(cpu_w_wen),
        .cpu_r_data(cpu_r_data4),
        .mem_r_addr(m4_r_addr), .mem_r_data(m4_r_data),
        .mem_w_addr(m4_w_addr), .mem_w_data(m4_w_data), .mem_w_wen(m4_w_wen),
        .hram_r_addr(h4_r_addr), .hram_r_data(h4_r_data),
        .hram_w_addr(h4_w_addr), .hram_w_data(h4_w_data), .hram_w_wen(h4_w_wen),
        .dma_active(act4), .dma_done(done4)
    );

    assign m1_r_data = mem1[m1_r_addr];
    assign m4_r_data = mem4[m4_r_addr];
    assign h1_r_data = hram1[h1_r_addr];
    assign h4_r_data = hram4[h4_r_addr];

    always @(posedge clk) begin
        if (pl_en && pl_sel == 0) mem1[pl_addr] <= pl_data;
        else if (m1_w_wen)        mem1[m1_w_addr] <= m1_w_data;
        if (pl_en && pl_sel == 1) mem4[pl_addr] <= pl_data;
        else if (m4_w_wen)        mem4[m4_w_addr] <= m4_w_data;
        if (h1_w_wen) hram1[h1_w_addr] <= h1_w_data;
        if (h4_w_wen) hram4[h4_w_addr] <= h4_w_data;
    end

    function automatic logic [7:0] pat(input int mode, input int i);
        case (mode)
            0:       return 8'(i ^ 'h5A);
            1:       return 8'(~i);
            2:       return 8'h11;
            3:       return 8'(i + 3);
            4:       return 8'(i + 1);
            default: return 8'hEE;
        endcase
    endfunction

    task automatic pl_fill(input int sel, input int base, input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            pl_sel  = sel;
            pl_addr = 16'(base + i);
            pl_data = pat(mode, i);
            pl_en   = 1'b1;
            @(negedge clk);
        end
        pl_en = 1'b0;
    endtask

    task automatic pl_byte(input int sel, input int addr, input logic [7:0] d);
        pl_sel = sel; pl_addr = 16'(addr); pl_data = d; pl_en = 1'b1;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic do_reset();
        cpu_w_wen = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Presents an FF46 write for one cycle; afterwards cyc = 1 (START cycle).
    task automatic start_dma(input logic [7:0] d);
        cpu_w_addr = 16'hFF46; cpu_w_data = d; cpu_w_wen = 1'b1;
        @(negedge clk);
        cpu_w_wen = 1'b0;
        cyc = 1;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic wait_done1();
        while (done1 !== 1'b1 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        cpu_r_addr = 16'hFF46;
        #1;
        compared++; if (act1 !== 1'b0) begin mismatched++; $display("FAIL reset_active1 got %b want 0", act1); end
        compared++; if (done1 !== 1'b0) begin mismatched++; $display("FAIL reset_done1 got %b want 0", done1); end
        compared++; if (act4 !== 1'b0) begin mismatched++; $display("FAIL reset_active4 got %b want 0", act4); end
        compared++; if (m1_w_wen !== 1'b0) begin mismatched++; $display("FAIL reset_mem_wen got %b want 0", m1_w_wen); end
        compared++; if (h1_w_wen !== 1'b0) begin mismatched++; $display("FAIL reset_hram_wen got %b want 0", h1_w_wen); end
        compared++; if (cpu_r_data1 !== 8'h00) begin mismatched++; $display("FAIL reset_ff46 got %h want 00", cpu_r_data1); end
        @(negedge clk);
    endtask

    task automatic test_basic_copy();
        do_reset();
        pl_fill(0, 'hC000, 160, 0);
        cpu_r_addr = 16'hFF46;
        start_dma(8'hC0);
        #1;
        compared++; if (act1 !== 1'b0) begin mismatched++; $display("FAIL start_not_active got %b want 0", act1); end
        run_to(2);
        #1;
        compared++; if (act1 !== 1'b1) begin mismatched++; $display("FAIL active_cycle2 got %b want 1", act1); end
        compared++; if (m1_r_addr !== 16'hC000) begin mismatched++; $display("FAIL first_src_addr got %h want c000", m1_r_addr); end
        wait_done1();
        compared++; if (cyc !== 162) begin mismatched++; $display("FAIL basic_done_cycle got %0d want 162", cyc); end
        compared++; if (act1 !== 1'b0) begin mismatched++; $display("FAIL basic_idle_at_done got %b want 0", act1); end
        @(negedge clk);
        compared++; if (done1 !== 1'b0) begin mismatched++; $display("FAIL done_one_cycle got %b want 0", done1); end
        for (int i = 0; i < 160; i++) begin
            compared++;
            if (mem1['hFE00 + i] !== pat(0, i)) begin
                mismatched++;
                $display("FAIL basic_oam[%0d] got %h want %h", i, mem1['hFE00 + i], pat(0, i));
            end
        end
        #1;
        compared++; if (cpu_r_data1 !== 8'hC0) begin mismatched++; $display("FAIL basic_ff46_read got %h want c0", cpu_r_data1); end
    endtask

    task automatic test_bus_lockout();
        do_reset();
        pl_byte(0, 'h0100, 8'h99);
        pl_byte(0, 'hC100, 8'h77);
        cpu_r_addr = 16'h0100;
        #1;
        compared++; if (cpu_r_data1 !== 8'h99) begin mismatched++; $display("FAIL idle_read_pass got %h want 99", cpu_r_data1); end
        cpu_w_addr = 16'hC200; cpu_w_data = 8'h55; cpu_w_wen = 1'b1;
        #1;
        compared++; if ({m1_w_wen, m1_w_addr, m1_w_data} !== {1'b1, 16'hC200, 8'h55}) begin
            mismatched++; $display("FAIL idle_write_pass got %b %h %h want 1 c200 55", m1_w_wen, m1_w_addr, m1_w_data);
        end
        cpu_w_wen = 1'b0;
        @(negedge clk);
        start_dma(8'hC0);
        run_to(5);
        cpu_r_addr = 16'h0100;
        cpu_w_addr = 16'hC100; cpu_w_data = 8'h12; cpu_w_wen = 1'b1;
        #1;
        compared++; if (cpu_r_data1 !== 8'hFF) begin mismatched++; $display("FAIL lockout_read got %h want ff", cpu_r_data1); end
        compared++; if (m1_w_addr !== 16'hFE03) begin mismatched++; $display("FAIL lockout_waddr got %h want fe03", m1_w_addr); end
        @(negedge clk); cyc++;
        cpu_w_addr = 16'hFF90; cpu_w_data = 8'h34;
        #1;
        compared++; if ({h1_w_wen, m1_w_wen} !== 2'b11) begin mismatched++; $display("FAIL hram_and_dma_same_cycle got %b want 11", {h1_w_wen, m1_w_wen}); end
        @(negedge clk); cyc++;
        cpu_w_wen = 1'b0;
        cpu_r_addr = 16'hFF90;
        #1;
        compared++; if (cpu_r_data1 !== 8'h34) begin mismatched++; $display("FAIL hram_read_active got %h want 34", cpu_r_data1); end
        cpu_r_addr = 16'hFF46;
        #1;
        compared++; if (cpu_r_data1 !== 8'hC0) begin mismatched++; $display("FAIL ff46_read_active got %h want c0", cpu_r_data1); end
        wait_done1();
        compared++; if (cyc !== 162) begin mismatched++; $display("FAIL lockout_done_cycle got %0d want 162", cyc); end
        compared++; if (mem1['hC100] !== 8'h77) begin mismatched++; $display("FAIL dropped_write got %h want 77", mem1['hC100]); end
        compared++; if (mem1['hFE05] !== pat(0, 5)) begin mismatched++; $display("FAIL lockout_oam5 got %h want %h", mem1['hFE05], pat(0, 5)); end
    endtask

    task automatic test_slot_timing();
        int wcount;
        int last;
        int expc;
        do_reset();
        pl_fill(1, 'h8000, 160, 3);
        start_dma(8'h80);
        wcount = 0;
        last = 0;
        while (done4 !== 1'b1 && cyc < 2000) begin
            if (m4_w_wen === 1'b1) begin
                wcount++;
                expc = (wcount == 1) ? 2 : last + 4;
                compared++;
                if (cyc !== expc) begin mismatched++; $display("FAIL slot_wen_%0d at cycle %0d want %0d", wcount, cyc, expc); end
                last = cyc;
            end
            @(negedge clk);
            cyc++;
        end
        compared++; if (cyc !== 642) begin mismatched++; $display("FAIL slot_done_cycle got %0d want 642", cyc); end
        compared++; if (wcount !== 160) begin mismatched++; $display("FAIL slot_wen_count got %0d want 160", wcount); end
        compared++; if (mem4['hFE00] !== 8'h03) begin mismatched++; $display("FAIL slot_oam0 got %h want 03", mem4['hFE00]); end
        compared++; if (mem4['hFE9F] !== 8'hA2) begin mismatched++; $display("FAIL slot_oam159 got %h want a2", mem4['hFE9F]); end
    endtask

    task automatic test_source_clamp();
        do_reset();
        pl_fill(0, 'hC100, 160, 1);
        pl_fill(0, 'hE100, 160, 2);
        start_dma(8'hE1);
        run_to(2);
        #1;
        compared++; if (m1_r_addr !== 16'hC100) begin mismatched++; $display("FAIL clamp_src_addr got %h want c100", m1_r_addr); end
        wait_done1();
        compared++; if (cyc !== 162) begin mismatched++; $display("FAIL clamp_done_cycle got %0d want 162", cyc); end
        compared++; if (mem1['hFE00] !== 8'hFF) begin mismatched++; $display("FAIL clamp_oam0 got %h want ff", mem1['hFE00]); end
        compared++; if (mem1['hFE00 + 77] !== pat(1, 77)) begin mismatched++; $display("FAIL clamp_oam77 got %h want %h", mem1['hFE00 + 77], pat(1, 77)); end
        compared++; if (mem1['hFE9F] !== pat(1, 159)) begin mismatched++; $display("FAIL clamp_oam159 got %h want %h", mem1['hFE9F], pat(1, 159)); end
        cpu_r_addr = 16'hFF46;
        #1;
        compared++; if (cpu_r_data1 !== 8'hE1) begin mismatched++; $display("FAIL clamp_ff46_read got %h want e1", cpu_r_data1); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        pl_fill(0, 'hC000, 160, 0);
        pl_fill(0, 'hFE00, 160, 9);
        start_dma(8'hC0);
        // Reset is sampled on the edge that would move the transfer to idx 50.
        run_to(51);
        rst = 1'b1;
        @(negedge clk); cyc++;
        #1;
        compared++; if (act1 !== 1'b0) begin mismatched++; $display("FAIL rstmid_active got %b want 0", act1); end
        compared++; if (done1 !== 1'b0) begin mismatched++; $display("FAIL rstmid_done got %b want 0", done1); end
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            compared++; if (done1 !== 1'b0) begin mismatched++; $display("FAIL rstmid_no_done_%0d got %b want 0", k, done1); end
        end
        compared++; if (mem1['hFE00] !== pat(0, 0)) begin mismatched++; $display("FAIL rstmid_oam0 got %h want %h", mem1['hFE00], pat(0, 0)); end
        compared++; if (mem1['hFE00 + 49] !== pat(0, 49)) begin mismatched++; $display("FAIL rstmid_oam49 got %h want %h", mem1['hFE00 + 49], pat(0, 49)); end
        compared++; if (mem1['hFE00 + 50] !== 8'hEE) begin mismatched++; $display("FAIL rstmid_oam50 got %h want ee", mem1['hFE00 + 50]); end
        compared++; if (mem1['hFE9F] !== 8'hEE) begin mismatched++; $display("FAIL rstmid_oam159 got %h want ee", mem1['hFE9F]); end
    endtask

    task automatic test_ff46_midway();
        int exp_done;
        int exp_mode;
`ifdef SM83_DMA_RESTART_EN
        exp_done = 244;
        exp_mode = 4;
`else
        exp_done = 162;
        exp_mode = 0;
`endif
        do_reset();
        pl_fill(0, 'hD000, 160, 4);
        pl_fill(0, 'hFE00, 160, 9);
        start_dma(8'hC0);
        run_to(82);
        cpu_w_addr = 16'hFF46; cpu_w_data = 8'hD0; cpu_w_wen = 1'b1;
        @(negedge clk); cyc++;
        cpu_w_wen = 1'b0;
        cpu_r_addr = 16'hFF46;
        #1;
        compared++; if (cpu_r_data1 !== 8'hD0) begin mismatched++; $display("FAIL midway_readback got %h want d0", cpu_r_data1); end
        wait_done1();
        compared++; if (cyc !== exp_done) begin mismatched++; $display("FAIL midway_done_cycle got %0d want %0d", cyc, exp_done); end
        compared++; if (mem1['hFE00] !== pat(exp_mode, 0)) begin mismatched++; $display("FAIL midway_oam0 got %h want %h", mem1['hFE00], pat(exp_mode, 0)); end
        compared++; if (mem1['hFE00 + 80] !== pat(exp_mode, 80)) begin mismatched++; $display("FAIL midway_oam80 got %h want %h", mem1['hFE00 + 80], pat(exp_mode, 80)); end
        compared++; if (mem1['hFE9F] !== pat(exp_mode, 159)) begin mismatched++; $display("FAIL midway_oam159 got %h want %h", mem1['hFE9F], pat(exp_mode, 159)); end
    endtask

    initial begin
        test_reset();
        test_basic_copy();
        test_bus_lockout();
        test_slot_timing();
        test_source_clamp();
        test_reset_mid();
        test_ff46_midway();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
